stream_packet_mux: RTL and testbench
====================================

STREAM_PACKET_MUX -- requirements
Module: stream_packet_mux

Interface
REQ-001 Parameter STREAM_COUNT, default 2, number of input streams (>=2).
REQ-002 Parameter T_DATA_WIDTH, default 8, data width per beat.
REQ-003 Parameter T_QOS__WIDTH, default 4, QoS width; 0 means "no priority".
REQ-004 Parameter T_ID___WIDTH, default $clog2(STREAM_COUNT), width of stream index.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 nrst  in  1  asynchronous, active-low reset.
REQ-007 s_valid  in  [STREAM_COUNT]  per-stream beat valid.
REQ-008 s_data  in  [STREAM_COUNT][T_DATA_WIDTH]  per-stream data.
REQ-009 s_qos  in  [STREAM_COUNT][T_QOS__WIDTH]  per-stream QoS, sampled with each beat.
REQ-010 s_last  in  [STREAM_COUNT]  per-stream end-of-packet marker.
REQ-011 s_ready  out  [STREAM_COUNT]  per-stream beat accept.
REQ-012 arb_en  out  1  one-cycle request to arbiter to evaluate and update its round-robin pointer.
REQ-013 arb_req  out  [STREAM_COUNT]  equals s_valid.
REQ-014 arb_qos  out  [STREAM_COUNT][T_QOS__WIDTH]  equals s_qos.
REQ-015 arb_grant  in  [STREAM_COUNT]  one-hot grant from arbiter, valid in the cycle after arb_en.
REQ-016 m_valid, m_data, m_qos, m_last, m_id  out  1/T_DATA_WIDTH/T_QOS__WIDTH/1/T_ID___WIDTH  registered output stream.
REQ-017 m_ready  in  1  downstream accept.

Function
REQ-018 A handshake occurs on any interface when valid and ready are both high at a rising clk edge.
REQ-019 FSM states SHALL be IDLE, ARB, XFER.
REQ-020 IDLE: arb_en high iff |s_valid; if so next state ARB, else stay IDLE.
REQ-021 ARB: arb_en low; if arb_grant is exactly one-hot, latch its bit index into sel and go XFER; if zero or multi-hot, go IDLE without latching.
REQ-022 XFER: s_ready[sel] = (!m_valid | m_ready); all other s_ready bits 0; arb_en 0.
REQ-023 s_ready SHALL be all-zero in IDLE and ARB.
REQ-024 On an input handshake, output register loads s_data[sel], s_qos[sel], s_last[sel], m_id=sel, and m_valid=1 at the next edge.
REQ-025 If m_valid & m_ready and no input handshake in the same cycle, m_valid clears next edge.
REQ-026 Output register contents SHALL NOT change while m_valid & !m_ready.
REQ-027 Input handshake with s_last[sel]=1 SHALL move FSM to IDLE; sel held until next ARB.
REQ-028 No beat of any other stream is accepted between sel latch and sel's last-beat handshake (packet lock).
REQ-029 Latency: input handshake to m_valid = 1 cycle; back-to-back beats at full rate when m_ready stays high.
REQ-030 Minimum inter-packet gap on input side: 2 cycles (IDLE, ARB) after last-beat handshake.
REQ-031 A stream dropping s_valid mid-packet in XFER SHALL leave FSM in XFER (no timeout).
REQ-032 Single-beat packet (s_last on first beat) SHALL be accepted and return FSM to IDLE.

Reset
REQ-033 On nrst low: FSM=IDLE, sel=0, m_valid=0, m_last=0, m_data=0, m_qos=0, m_id=0, arb_en=0, s_ready=0, immediately and asynchronously.
REQ-034 Reset mid-packet SHALL discard the in-flight output beat and the packet lock; first cycle after release behaves as IDLE.

Verification
REQ-035 STREAM_COUNT=2, s_valid=01, arb_grant=01 in ARB, 3-beat packet 0xA1,0xA2,0xA3(last), m_ready=1 -> m_data A1,A2,A3 on consecutive cycles, m_id=0, m_last only on A3, FSM IDLE after.
REQ-036 Both streams valid, grant=10, stream 0 stays valid during stream 1 packet -> s_ready[0]=0 throughout, outputs carry m_id=1 only until its last beat.
REQ-037 m_ready=0 for 4 cycles with m_valid=1, data 0x55 -> m_data held 0x55, s_ready[sel]=0, no input beat lost; release -> next beat follows next cycle.
REQ-038 arb_grant=00 then 11 in ARB -> FSM returns IDLE, no s_ready asserted, arb_en re-pulses next IDLE cycle.
REQ-039 nrst pulsed low during beat 2 of 4 -> m_valid=0 immediately, FSM IDLE, new ARB cycle follows release.
REQ-040 Single-beat packets alternating streams 0,1 with grants 01,10 -> each accepted, 2-cycle input gap between them, m_last=1 on every output beat.

Source files
------------

// File: rtl/stream_packet_mux.sv
// Packet-locked N:1 stream multiplexer driven by an external round-robin arbiter.
// One packet at a time is forwarded through a single registered output stage.
module stream_packet_mux #(
  parameter int STREAM_COUNT = 2,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  localparam int QW = (T_QOS__WIDTH > 0) ? T_QOS__WIDTH : 1
) (
  input  logic                                       clk,
  input  logic                                       nrst,
  input  logic [STREAM_COUNT-1:0]                    s_valid,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data,
  input  logic [STREAM_COUNT-1:0][QW-1:0]            s_qos,
  input  logic [STREAM_COUNT-1:0]                    s_last,
  output logic [STREAM_COUNT-1:0]                    s_ready,
  output logic                                       arb_en,
  output logic [STREAM_COUNT-1:0]                    arb_req,
  output logic [STREAM_COUNT-1:0][QW-1:0]            arb_qos,
  input  logic [STREAM_COUNT-1:0]                    arb_grant,
  output logic                                       m_valid,
  output logic [T_DATA_WIDTH-1:0]                    m_data,
  output logic [QW-1:0]                              m_qos,
  output logic                                       m_last,
  output logic [T_ID___WIDTH-1:0]                    m_id,
  input  logic                                       m_ready
);

  localparam int IW = T_ID___WIDTH;
  localparam logic [STREAM_COUNT-1:0] GRANT_ONE = {{(STREAM_COUNT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   sel_r;
  logic [IW-1:0]   sel_nxt_s;
  logic [IW-1:0]   grant_idx_s;
  logic            grant_onehot_s;
  logic            out_free_s;
  logic            in_hs_s;

  assign arb_req = s_valid;
  assign arb_qos = s_qos;

  assign out_free_s     = !m_valid || m_ready;
  assign in_hs_s        = (state_r == XFER) && s_valid[sel_r] && out_free_s;
  assign grant_onehot_s = (arb_grant != {STREAM_COUNT{1'b0}}) &&
                          ((arb_grant & (arb_grant - GRANT_ONE)) == {STREAM_COUNT{1'b0}});

  // Grant decode: OR of the indices of set bits; only meaningful when one-hot.
  always_comb begin
    grant_idx_s = {IW{1'b0}};
    for (int i = 0; i < STREAM_COUNT; i++) begin
      grant_idx_s = grant_idx_s | ({IW{arb_grant[i]}} & IW'(i));
    end
  end

  // Next-state, selection and handshake outputs.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    arb_en      = 1'b0;
    s_ready     = {STREAM_COUNT{1'b0}};
    case (state_r)
      IDLE: begin
        if (|s_valid) begin
          // arb_en is combinational, so it is also held low while reset is asserted.
          arb_en      = nrst;
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARB: begin
        if (grant_onehot_s) begin
          sel_nxt_s   = grant_idx_s;
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        s_ready[sel_r] = out_free_s;
        if (in_hs_s && s_last[sel_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state and packet-lock selection register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      sel_r   <= {IW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
    end
  end

  // Output stage: loads on input handshake, otherwise drains or holds.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_valid <= 1'b0;
      m_data  <= {T_DATA_WIDTH{1'b0}};
      m_qos   <= {QW{1'b0}};
      m_last  <= 1'b0;
      m_id    <= {IW{1'b0}};
    end else if (in_hs_s) begin
      m_valid <= 1'b1;
      m_data  <= s_data[sel_r];
      m_qos   <= s_qos[sel_r];
      m_last  <= s_last[sel_r];
      m_id    <= sel_r;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= m_valid;
    end
  end

endmodule

// File: tb/tb_stream_packet_mux.sv
// Self-checking bench for stream_packet_mux: vector table plus scoreboarded
// hand sequences; the bench plays the role of the arbiter.
module tb_stream_packet_mux;

  logic            clk;
  logic            nrst;
  logic [1:0]      s_valid;
  logic [1:0][7:0] s_data;
  logic [1:0][3:0] s_qos;
  logic [1:0]      s_last;
  logic [1:0]      s_ready;
  logic            arb_en;
  logic [1:0]      arb_req;
  logic [1:0][3:0] arb_qos;
  logic [1:0]      arb_grant;
  logic            m_valid;
  logic [7:0]      m_data;
  logic [3:0]      m_qos;
  logic            m_last;
  logic [0:0]      m_id;
  logic            m_ready;

  stream_packet_mux #(
    .STREAM_COUNT(2),
    .T_DATA_WIDTH(8),
    .T_QOS__WIDTH(4)
  ) dut (
    .clk(clk), .nrst(nrst),
    .s_valid(s_valid), .s_data(s_data), .s_qos(s_qos), .s_last(s_last), .s_ready(s_ready),
    .arb_en(arb_en), .arb_req(arb_req), .arb_qos(arb_qos), .arb_grant(arb_grant),
    .m_valid(m_valid), .m_data(m_data), .m_qos(m_qos), .m_last(m_last), .m_id(m_id),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] last;
    logic [1:0] grant;
    logic       mr;
    logic       tbl;
    logic       x_en;
    logic [1:0] x_rdy;
    logic       x_mv;
    logic [7:0] x_md;
    logic       x_ml;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] q;
    logic       l;
    logic       id;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    st    = 0;     // model state: 0 IDLE, 1 ARB, 2 XFER
  logic  msel  = 1'b0;
  vec_t  tab[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] last, input logic [1:0] grant, input logic mr);
    vec_t t;
    t.v = v; t.d0 = d0; t.d1 = d1; t.last = last; t.grant = grant; t.mr = mr;
    t.tbl = 1'b0; t.x_en = 1'b0; t.x_rdy = 2'b00; t.x_mv = 1'b0; t.x_md = 8'h00; t.x_ml = 1'b0;
    return t;
  endfunction

  function automatic vec_t mkx(input logic [1:0] v, input logic [7:0] d0, input logic [1:0] last,
                               input logic [1:0] grant, input logic x_en, input logic [1:0] x_rdy,
                               input logic x_mv, input logic [7:0] x_md, input logic x_ml);
    vec_t t;
    t = mk(v, d0, 8'h00, last, grant, 1'b1);
    t.tbl = 1'b1; t.x_en = x_en; t.x_rdy = x_rdy; t.x_mv = x_mv; t.x_md = x_md; t.x_ml = x_ml;
    return t;
  endfunction

  // One clock of stimulus: drive at negedge, check just after, advance model at posedge.
  task automatic cyc(input vec_t t);
    logic [1:0] xr;
    logic       xe;
    logic       ihs;
    logic [7:0] dsel;
    @(negedge clk);
    s_valid   = t.v;
    s_data[0] = t.d0;
    s_data[1] = t.d1;
    s_qos[0]  = t.d0[7:4];
    s_qos[1]  = t.d1[7:4];
    s_last    = t.last;
    arb_grant = t.grant;
    m_ready   = t.mr;
    #1;
    xe = (st == 0) && (t.v != 2'b00);
    xr = 2'b00;
    if (st == 2) xr[msel] = (sb.size() == 0) || t.mr;
    chk("arb_en", {31'd0, arb_en}, {31'd0, xe});
    chk("s_ready", {30'd0, s_ready}, {30'd0, xr});
    chk("arb_req", {30'd0, arb_req}, {30'd0, t.v});
    chk("arb_qos", {24'd0, arb_qos}, {24'd0, t.d1[7:4], t.d0[7:4]});
    chk("m_valid", {31'd0, m_valid}, {31'd0, (sb.size() != 0)});
    if (sb.size() != 0) begin
      chk("m_data", {24'd0, m_data}, {24'd0, sb[0].d});
      chk("m_qos", {28'd0, m_qos}, {28'd0, sb[0].q});
      chk("m_last", {31'd0, m_last}, {31'd0, sb[0].l});
      chk("m_id", {31'd0, m_id}, {31'd0, sb[0].id});
    end
    if (t.tbl) begin
      chk("tbl_arb_en", {31'd0, arb_en}, {31'd0, t.x_en});
      chk("tbl_s_ready", {30'd0, s_ready}, {30'd0, t.x_rdy});
      chk("tbl_m_valid", {31'd0, m_valid}, {31'd0, t.x_mv});
      if (t.x_mv) begin
        chk("tbl_m_data", {24'd0, m_data}, {24'd0, t.x_md});
        chk("tbl_m_last", {31'd0, m_last}, {31'd0, t.x_ml});
        chk("tbl_m_id", {31'd0, m_id}, 32'd0);
      end
    end
    @(posedge clk);
    ihs  = (st == 2) && t.v[msel] && xr[msel];
    dsel = msel ? t.d1 : t.d0;
    if ((sb.size() != 0) && t.mr) void'(sb.pop_front());
    if (ihs) sb.push_back('{dsel, dsel[7:4], t.last[msel], msel});
    case (st)
      0: st = (t.v != 2'b00) ? 1 : 0;
      1: begin
        if ($countones(t.grant) == 1) begin
          msel = t.grant[1];
          st   = 2;
        end else begin
          st = 0;
        end
      end
      2: if (ihs && t.last[msel]) st = 0;
      default: st = 0;
    endcase
  endtask

  // Asynchronous reset pulse with immediate checks while nrst is low.
  task automatic do_reset();
    #2;
    nrst = 1'b0;
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_m_qos", {28'd0, m_qos}, 32'd0);
    chk("rst_m_id", {31'd0, m_id}, 32'd0);
    chk("rst_arb_en", {31'd0, arb_en}, 32'd0);
    chk("rst_s_ready", {30'd0, s_ready}, 32'd0);
    st = 0;
    msel = 1'b0;
    sb.delete();
    s_valid = 2'b00;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; s_valid = 2'b01; s_data = '{8'h00, 8'h00}; s_qos = '{4'h0, 4'h0};
    s_last = 2'b00; arb_grant = 2'b00; m_ready = 1'b1;

    tab[0] = mkx(2'b01, 8'hA1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
    tab[1] = mkx(2'b01, 8'hA1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    tab[2] = mkx(2'b01, 8'hA1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0);
    tab[3] = mkx(2'b01, 8'hA2, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 8'hA1, 1'b0);
    tab[4] = mkx(2'b01, 8'hA3, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 8'hA2, 1'b0);
    tab[5] = mkx(2'b00, 8'hA3, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 8'hA3, 1'b1);
    tab[6] = mkx(2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);

    do_reset();

    // Three-beat packet from stream 0 at full rate.
    for (int i = 0; i < 7; i++) cyc(tab[i]);

    // Stream 1 granted while stream 0 keeps requesting; stream 1 stalls mid-packet.
    cyc(mk(2'b11, 8'hC0, 8'hB1, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b11, 8'hC0, 8'hB1, 2'b00, 2'b10, 1'b1));
    cyc(mk(2'b11, 8'hC0, 8'hB1, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'hC0, 8'hB2, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b11, 8'hC0, 8'hB2, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b11, 8'hC0, 8'hB3, 2'b10, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'hC0, 8'h00, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'hC0, 8'h00, 2'b00, 2'b01, 1'b1));
    cyc(mk(2'b01, 8'hC0, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1));

    // Downstream backpressure for four cycles with 0x55 held.
    cyc(mk(2'b01, 8'h55, 8'h00, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h55, 8'h00, 2'b00, 2'b01, 1'b1));
    cyc(mk(2'b01, 8'h55, 8'h00, 2'b00, 2'b00, 1'b1));
    for (int i = 0; i < 4; i++) cyc(mk(2'b01, 8'h66, 8'h00, 2'b01, 2'b00, 1'b0));
    cyc(mk(2'b01, 8'h66, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1));

    // Zero and multi-hot grants fall back to IDLE and re-request.
    cyc(mk(2'b01, 8'h77, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h77, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h77, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h77, 8'h00, 2'b01, 2'b11, 1'b1));
    cyc(mk(2'b01, 8'h77, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h77, 8'h00, 2'b01, 2'b01, 1'b1));
    cyc(mk(2'b01, 8'h77, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1));

    // Reset during beat 2 of a 4-beat packet, then a fresh packet.
    cyc(mk(2'b01, 8'h81, 8'h00, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h81, 8'h00, 2'b00, 2'b01, 1'b1));
    cyc(mk(2'b01, 8'h81, 8'h00, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h82, 8'h00, 2'b00, 2'b00, 1'b1));
    do_reset();
    cyc(mk(2'b01, 8'h91, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b01, 8'h91, 8'h00, 2'b01, 2'b01, 1'b1));
    cyc(mk(2'b01, 8'h91, 8'h00, 2'b01, 2'b00, 1'b1));
    cyc(mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1));

    // Single-beat packets alternating between streams.
    cyc(mk(2'b11, 8'hD0, 8'hE1, 2'b11, 2'b00, 1'b1));
    cyc(mk(2'b11, 8'hD0, 8'hE1, 2'b11, 2'b01, 1'b1));
    cyc(mk(2'b11, 8'hD0, 8'hE1, 2'b11, 2'b00, 1'b1));
    cyc(mk(2'b10, 8'hD0, 8'hE1, 2'b11, 2'b00, 1'b1));
    cyc(mk(2'b10, 8'hD0, 8'hE1, 2'b11, 2'b10, 1'b1));
    cyc(mk(2'b10, 8'hD0, 8'hE1, 2'b11, 2'b00, 1'b1));
    cyc(mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1));
    cyc(mk(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
